// File: rtl/miner_job_master.sv
// Job sequencer for a memory-mapped miner slave: loads target and message words,
// starts the hash, polls status until a nonce is found, the poll budget runs out, or the job is aborted.
module miner_job_master #(
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_start,
    input  logic [255:0] job_target,
    input  logic [607:0] job_msg,
    input  logic         job_abort,
    output logic         busy,
    output logic         nonce_valid,
    output logic [31:0]  nonce,
    output logic         timeout,
    output logic [4:0]   masterAddr,
    output logic [31:0]  masterWriteData,
    output logic         masterWrite,
    output logic         masterRead,
    output logic         masterChipSelect,
    input  logic [31:0]  masterReadData
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_TGT,
        S_WR_CMD1,
        S_WR_MSG,
        S_WR_CMD2,
        S_POLL_RD,
        S_POLL_WAIT,
        S_POLL_GAP,
        S_NONCE_RD,
        S_NONCE_WAIT
    } state_t;

    localparam logic [15:0] MAX_POLLS_W = 16'(MAX_POLLS);
    localparam logic [7:0]  GAP_LOAD    = 8'(POLL_GAP - 1);
    localparam logic [31:0] STATUS_FOUND = 32'h3;

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [7:0]     gap_q, gap_d;
    logic [15:0]    polls_q, polls_d;
    logic [255:0]   tgt_q, tgt_d;
    logic [607:0]   msg_q, msg_d;
    logic [31:0]    nonce_q, nonce_d;
    logic           nonce_valid_q, nonce_valid_d;
    logic           timeout_q, timeout_d;
    logic           busy_q, busy_d;
    logic           wr_q, wr_d;
    logic           rd_q, rd_d;
    logic           cs_q, cs_d;
    logic [4:0]     addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;

    logic [2:0]     tgt_word;
    logic [4:0]     msg_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            gap_q         <= '0;
            polls_q       <= '0;
            tgt_q         <= '0;
            msg_q         <= '0;
            nonce_q       <= '0;
            nonce_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            wr_q          <= 1'b0;
            rd_q          <= 1'b0;
            cs_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            polls_q       <= polls_d;
            tgt_q         <= tgt_d;
            msg_q         <= msg_d;
            nonce_q       <= nonce_d;
            nonce_valid_q <= nonce_valid_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            cs_q          <= cs_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        polls_d       = polls_q;
        tgt_d         = tgt_q;
        msg_d         = msg_q;
        nonce_d       = nonce_q;
        nonce_valid_d = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    tgt_d   = job_target;
                    msg_d   = job_msg;
                    polls_d = '0;
                    idx_d   = '0;
                    state_d = S_WR_TGT;
                end
            end
            S_WR_TGT: begin
                if (idx_q == 5'd7) begin
                    idx_d   = '0;
                    state_d = S_WR_CMD1;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_WR_CMD1: begin
                idx_d   = '0;
                state_d = S_WR_MSG;
            end
            S_WR_MSG: begin
                if (idx_q == 5'd18) begin
                    idx_d   = '0;
                    state_d = S_WR_CMD2;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_WR_CMD2: begin
                state_d = S_POLL_RD;
            end
            S_POLL_RD: begin
                if (polls_q < MAX_POLLS_W) begin
                    polls_d = polls_q + 16'd1;
                end
                state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (masterReadData == STATUS_FOUND) begin
                    state_d = S_NONCE_RD;
                end else if (polls_q >= MAX_POLLS_W) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (POLL_GAP == 0) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_d   = GAP_LOAD;
                    state_d = S_POLL_GAP;
                end
            end
            S_POLL_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_NONCE_RD: begin
                state_d = S_NONCE_WAIT;
            end
            S_NONCE_WAIT: begin
                nonce_d       = masterReadData;
                nonce_valid_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a found status or nonce capture this cycle.
        if (job_abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            nonce_d       = nonce_q;
            nonce_valid_d = 1'b0;
            timeout_d     = 1'b0;
        end
    end

    // Bus signals are decoded from the next state so they land in flops aligned with that state.
    always_comb begin
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tgt_word = 3'd7 - idx_d[2:0];
        msg_word = 5'd18 - idx_d;

        case (state_d)
            S_WR_TGT: begin
                wr_d    = 1'b1;
                addr_d  = 5'd9 - idx_d;
                wdata_d = tgt_d[{tgt_word, 5'b0} +: 32];
            end
            S_WR_CMD1: begin
                wr_d    = 1'b1;
                addr_d  = 5'd1;
                wdata_d = 32'h1;
            end
            S_WR_MSG: begin
                wr_d    = 1'b1;
                addr_d  = 5'd29 - idx_d;
                wdata_d = msg_d[{msg_word, 5'b0} +: 32];
            end
            S_WR_CMD2: begin
                wr_d    = 1'b1;
                addr_d  = 5'd1;
                wdata_d = 32'h2;
            end
            S_POLL_RD: begin
                rd_d   = 1'b1;
                addr_d = 5'd0;
            end
            S_NONCE_RD: begin
                rd_d   = 1'b1;
                addr_d = 5'd10;
            end
            default: begin
                wr_d = 1'b0;
                rd_d = 1'b0;
            end
        endcase

        cs_d   = wr_d | rd_d;
        busy_d = (state_d != S_IDLE);
    end

    assign busy             = busy_q;
    assign nonce_valid      = nonce_valid_q;
    assign nonce            = nonce_q;
    assign timeout          = timeout_q;
    assign masterAddr       = addr_q;
    assign masterWriteData  = wdata_q;
    assign masterWrite      = wr_q;
    assign masterRead       = rd_q;
    assign masterChipSelect = cs_q;

endmodule

// File: doc/miner_job_master.md
MINER_JOB_MASTER -- requirements
Module: miner_job_master

Interface
REQ-001 Parameter POLL_GAP, default 4: idle cycles between a non-found status read and the next status read; legal range 0..255.
REQ-002 Parameter MAX_POLLS, default 1024: status reads issued before the job is abandoned; legal range 1..65535.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 job_start  in  1  one-cycle request to run a job; honoured only in IDLE.
REQ-006 job_target  in  256  difficulty target; sampled when job_start is accepted.
REQ-007 job_msg  in  608  19-word message; sampled when job_start is accepted.
REQ-008 job_abort  in  1  cancel the running job.
REQ-009 busy  out  1  high while a job is in progress.
REQ-010 nonce_valid  out  1  one-cycle pulse: nonce holds a new result.
REQ-011 nonce  out  32  last nonce found; held until the next nonce_valid.
REQ-012 timeout  out  1  one-cycle pulse: MAX_POLLS reached without a found status.
REQ-013 masterAddr  out  5  register word address into the miner slave.
REQ-014 masterWriteData  out  32  write data.
REQ-015 masterWrite  out  1  write strobe; one word per cycle.
REQ-016 masterRead  out  1  read strobe.
REQ-017 masterChipSelect  out  1  high whenever masterWrite or masterRead is high.
REQ-018 masterReadData  in  32  read data, valid the cycle after masterRead (fixed latency 1).

Function
REQ-019 FSM states: IDLE, WR_TGT, WR_CMD1, WR_MSG, WR_CMD2, POLL_RD, POLL_WAIT, POLL_GAP, NONCE_RD, NONCE_WAIT.
REQ-020 Edge E0 is the edge that samples job_start high in IDLE; it registers job_target and job_msg and sets busy from cycle 1. job_start outside IDLE is ignored.
REQ-021 WR_TGT, cycles 1-8: write addresses 9,8,...,2 with target[255:224] down to target[31:0], one word per cycle.
REQ-022 WR_CMD1, cycle 9: write address 1 with 32'h1.
REQ-023 WR_MSG, cycles 10-28: write addresses 29,28,...,11 with msg[607:576] down to msg[31:0].
REQ-024 WR_CMD2, cycle 29: write address 1 with 32'h2.
REQ-025 POLL_RD, cycle 30: read address 0 and increment the poll count. POLL_WAIT, cycle 31: sample masterReadData.
REQ-026 If the sampled status equals 32'h3, go to NONCE_RD: read address 10, cycle 32. Then NONCE_WAIT, cycle 33: capture nonce.
REQ-027 At the nonce capture, the cycle after capture (cycle 34) asserts nonce_valid for one cycle with busy low and the FSM in IDLE. A job_start at edge 34 is accepted.
REQ-028 If the status is not 3 and the poll count is below MAX_POLLS: hold POLL_GAP idle bus cycles, then return to POLL_RD. With POLL_GAP=0, go directly to POLL_RD.
REQ-029 If the status is not 3 and the poll count equals MAX_POLLS: the next cycle pulses timeout with busy low and the FSM in IDLE. nonce is unchanged.
REQ-030 Outside write and read cycles, masterWrite, masterRead and masterChipSelect are 0; masterAddr and masterWriteData are don't-care but registered.
REQ-031 Bus outputs are registered: no combinational path from any input to any master output.
REQ-032 job_abort, sampled high in any non-IDLE state, sets the next cycle to IDLE with busy 0 and bus strobes 0, and pulses neither nonce_valid nor timeout.
REQ-033 If job_abort and a found status arrive in the same cycle, abort wins.
REQ-034 The poll count is 16 bits, cleared at job acceptance, and saturates at MAX_POLLS.
REQ-035 job_abort in IDLE has no effect.

Reset
REQ-036 rst high at an edge forces IDLE. busy, nonce_valid, timeout, masterWrite, masterRead and masterChipSelect are 0; nonce is 32'h0; the poll count is 0; captured job registers are 0.
REQ-037 rst takes priority over job_start and job_abort. Reset mid-job stops all bus activity from the next cycle with no pulses.

Verification
REQ-038 job_target = 256'h1000...0, job_msg = "a" zero-padded -> cycles 1-29 show 29 writes in the exact address/data order 9..2, 1=1, 29..11, 1=2.
REQ-039 Slave model returns status 1 twice, then 3, then nonce 32'h0000_00A5 -> reads at cycles 30, 36 and 42 (POLL_GAP=4); nonce read at cycle 44; nonce_valid and nonce=32'hA5 at cycle 46.
REQ-040 MAX_POLLS=3 with status always 0 -> exactly 3 status reads, timeout pulse once, nonce unchanged, busy low.
REQ-041 job_abort at cycle 15 -> no bus strobes from cycle 16; busy 0; a new job_start at cycle 17 restarts with an address-9 write at cycle 18.
REQ-042 rst at cycle 31 during POLL_WAIT -> all outputs at reset values the next cycle; a second job_start during busy is ignored.
